// File: rtl/tlb_inv_walker.sv
// INVTLB sequencer: on a committed invtlb it walks every TLB entry through the read
// port and clears E on entries that match the op/ASID/VA rule.
module tlb_inv_walker #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [9:0]      asid,
  input  logic [31:0]     va,
  output logic            busy,
  output logic            done,
  output logic            op_err,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  input  logic [9:0]      r_asid,
  input  logic            r_g,
  output logic            clr_en,
  output logic [IDXW-1:0] clr_index
);

  // Handshake: start is a one-cycle request, taken in IDLE or DONE and ignored while busy;
  // done (with op_err) is a one-cycle completion pulse; clr_en is a one-cycle write strobe.
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

  state_t          state, state_nx;
  logic [IDXW-1:0] idx;
  logic [4:0]      op_q;
  logic [9:0]      asid_q;
  logic [18:0]     vppn_q;
  logic            err_q;
  logic            accept;
  logic            asm_hit, v_hit, hit;
  logic            unused_va;

  assign unused_va = ^va[12:0];
  assign accept    = start && (state != SCAN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      idx    <= '0;
      op_q   <= '0;
      asid_q <= '0;
      vppn_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= op;
        asid_q <= asid;
        vppn_q <= va[31:13];
        err_q  <= (op > 5'd6);
        idx    <= '0;
      end else if (state == SCAN) begin
        idx <= (idx == LAST) ? '0 : idx + IDXW'(1);
      end
    end
  end

  // Large (2M) pages only compare the upper VPPN bits.
  always_comb begin
    asm_hit = (r_asid == asid_q);
    v_hit   = (r_ps == 6'd21) ? (vppn_q[18:9] == r_vppn[18:9]) : (vppn_q == r_vppn);
    case (op_q)
      5'd0, 5'd1: hit = 1'b1;
      5'd2:       hit = r_g;
      5'd3:       hit = ~r_g;
      5'd4:       hit = ~r_g & asm_hit;
      5'd5:       hit = ~r_g & asm_hit & v_hit;
      5'd6:       hit = (r_g | asm_hit) & v_hit;
      default:    hit = 1'b0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    op_err    = 1'b0;
    r_index   = '0;
    clr_en    = 1'b0;
    clr_index = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = (op > 5'd6) ? DONE : SCAN;
      end
      SCAN: begin
        busy      = 1'b1;
        r_index   = idx;
        clr_index = idx;
        clr_en    = r_e & hit;
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        op_err   = err_q;
        state_nx = start ? ((op > 5'd6) ? DONE : SCAN) : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_inv_walker.sv
// Self-checking bench for tlb_inv_walker: a TLB array model, a per-cycle expectation queue
// built from the match rules, directed cases plus randomized walks.
module tb_tlb_inv_walker;
  localparam int N = 16;

  logic        clk = 0;
  logic        resetn = 0;
  logic        start = 0;
  logic [4:0]  op = 0;
  logic [9:0]  asid = 0;
  logic [31:0] va = 0;
  logic        busy, done, op_err, clr_en;
  logic [3:0]  r_index, clr_index;
  logic        r_e, r_g;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;

  logic        t_e[N];
  logic [18:0] t_vppn[N];
  logic [5:0]  t_ps[N];
  logic [9:0]  t_asid[N];
  logic        t_g[N];

  // expectation word: [7] busy, [6] done, [5] op_err, [4] clr_en, [3:0] index
  logic [7:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int clr_cnt = 0, done_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = 0;

  tlb_inv_walker dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .asid(asid), .va(va),
    .busy(busy), .done(done), .op_err(op_err), .r_index(r_index),
    .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .clr_en(clr_en), .clr_index(clr_index)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign r_e    = t_e[r_index];
  assign r_vppn = t_vppn[r_index];
  assign r_ps   = t_ps[r_index];
  assign r_asid = t_asid[r_index];
  assign r_g    = t_g[r_index];

  always @(posedge clk) if (clr_en) t_e[clr_index] <= 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    if (!resetn) begin
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, op_err}, 0);
      check("rst_clr", {31'd0, clr_en}, 0);
      check("rst_r_index", {28'd0, r_index}, 0);
      check("rst_clr_index", {28'd0, clr_index}, 0);
    end else begin
      check("busy", {31'd0, busy}, {31'd0, e[7]});
      check("done", {31'd0, done}, {31'd0, e[6]});
      check("op_err", {31'd0, op_err}, {31'd0, e[5]});
      check("clr_en", {31'd0, clr_en}, {31'd0, e[4]});
      if (e[7]) check("r_index", {28'd0, r_index}, {28'd0, e[3:0]});
      if (e[4]) check("clr_index", {28'd0, clr_index}, {28'd0, e[3:0]});
      if (clr_en) clr_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // reference match rule straight from the op table
  function automatic bit will_clear(input int o, input logic [9:0] a, input logic [18:0] vp, input int i);
    bit am, vm;
    am = (t_asid[i] == a);
    vm = (t_ps[i] == 6'd21) ? ((vp >> 9) == (t_vppn[i] >> 9)) : (vp == t_vppn[i]);
    if (!t_e[i]) return 0;
    case (o)
      0, 1: return 1;
      2: return t_g[i];
      3: return !t_g[i];
      4: return !t_g[i] && am;
      5: return !t_g[i] && am && vm;
      6: return (t_g[i] || am) && vm;
      default: return 0;
    endcase
  endfunction

  // driver: called just after a rising edge; start is high for exactly one cycle
  task automatic issue(input logic [4:0] o, input logic [9:0] a, input logic [31:0] v);
    bit acc;
    acc = (exp_q.size() == 0) || (exp_q.size() == 1 && exp_q[0][6]);
    start = 1; op = o; asid = a; va = v;
    if (acc) begin
      start_cyc = cyc;
      if (exp_q.size() == 0) exp_q.push_back(8'h00);
      if (o > 6) exp_q.push_back(8'h60);
      else begin
        for (int i = 0; i < N; i++)
          exp_q.push_back({1'b1, 2'b00, will_clear(o, a, v[31:13], i), 4'(i)});
        exp_q.push_back(8'h40);
      end
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_size(input int n);
    int b = 0;
    while (exp_q.size() > n && b < 200) begin step(1); b++; end
    check("wait_timeout", {31'd0, (exp_q.size() > n)}, 0);
  endtask

  task automatic clear_tlb();
    for (int i = 0; i < N; i++) begin
      t_e[i] = 0; t_vppn[i] = 0; t_ps[i] = 6'd12; t_asid[i] = 0; t_g[i] = 0;
    end
  endtask

  task automatic set_ent(input int i, input logic [18:0] vp, input logic [5:0] ps,
                         input logic [9:0] a, input logic g);
    t_e[i] = 1; t_vppn[i] = vp; t_ps[i] = ps; t_asid[i] = a; t_g[i] = g;
  endtask

  task automatic begin_case();
    wait_size(0);
    clr_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    logic [18:0] pool[4];
    pool[0] = 19'h12A00; pool[1] = 19'h12A0F; pool[2] = 19'h00001; pool[3] = 19'h7FFFF;
    clear_tlb();
    step(3);
    resetn = 1;
    step(2);

    // 1: flush everything
    begin_case();
    for (int i = 0; i < N; i++) set_ent(i, 19'(i), 6'd12, 10'd1, 1'b0);
    issue(5'd0, 10'd0, 32'd0);
    wait_size(0); step(1);
    check("t1_clr_cnt", clr_cnt, 16);
    check("t1_done_lat", done_cyc - start_cyc, 17);
    check("t1_done_cnt", done_cnt, 1);

    // 2: non-global ASID match
    begin_case(); clear_tlb();
    set_ent(3, 19'h1, 6'd12, 10'd5, 1'b1);
    set_ent(7, 19'h2, 6'd12, 10'd5, 1'b0);
    set_ent(9, 19'h3, 6'd12, 10'd6, 1'b0);
    issue(5'd4, 10'd5, 32'd0);
    wait_size(0); step(1);
    check("t2_clr_cnt", clr_cnt, 1);
    check("t2_e7", {31'd0, t_e[7]}, 0);
    check("t2_e3", {31'd0, t_e[3]}, 1);
    check("t2_e9", {31'd0, t_e[9]}, 1);
    check("t2_done_lat", done_cyc - start_cyc, 17);

    // 3: 2M page VA match, then same with a 4K page
    begin_case(); clear_tlb();
    set_ent(2, 19'h12A00, 6'd21, 10'd5, 1'b0);
    issue(5'd5, 10'd5, 32'h2541_E000);
    wait_size(0); step(1);
    check("t3_big_clr", clr_cnt, 1);
    check("t3_big_e2", {31'd0, t_e[2]}, 0);
    begin_case(); clear_tlb();
    set_ent(2, 19'h12A00, 6'd12, 10'd5, 1'b0);
    issue(5'd5, 10'd5, 32'h2541_E000);
    wait_size(0); step(1);
    check("t3_small_clr", clr_cnt, 0);

    // 4: illegal op
    begin_case(); clear_tlb();
    for (int i = 0; i < N; i++) set_ent(i, 19'(i), 6'd12, 10'd0, 1'b1);
    issue(5'd7, 10'd0, 32'd0);
    wait_size(0); step(1);
    check("t4_clr", clr_cnt, 0);
    check("t4_done_lat", done_cyc - start_cyc, 1);
    check("t4_done_cnt", done_cnt, 1);

    // 5: start while busy is ignored
    begin_case(); clear_tlb();
    set_ent(1, 19'h1, 6'd12, 10'd0, 1'b1);
    set_ent(4, 19'h4, 6'd12, 10'd0, 1'b1);
    set_ent(10, 19'hA, 6'd12, 10'd0, 1'b1);
    set_ent(2, 19'h2, 6'd12, 10'd0, 1'b0);
    set_ent(6, 19'h6, 6'd12, 10'd0, 1'b0);
    issue(5'd2, 10'd0, 32'd0);
    step(3);
    issue(5'd0, 10'd0, 32'd0);
    wait_size(0); step(2);
    check("t5_clr", clr_cnt, 3);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_e2", {31'd0, t_e[2]}, 1);
    check("t5_e6", {31'd0, t_e[6]}, 1);

    // 6: reset in the middle of a walk
    begin_case(); clear_tlb();
    for (int i = 0; i < N; i++) set_ent(i, 19'(i), 6'd12, 10'd0, 1'b0);
    issue(5'd0, 10'd0, 32'd0);
    step(5);
    resetn = 0;
    exp_q.delete();
    #1;
    check("t6_busy_now", {31'd0, busy}, 0);
    step(2);
    resetn = 1;
    step(20);
    check("t6_clr", clr_cnt, 5);
    check("t6_done_cnt", done_cnt, 0);
    check("t6_e4", {31'd0, t_e[4]}, 0);
    check("t6_e5", {31'd0, t_e[5]}, 1);

    // randomized walks, some started in the DONE cycle of the previous one
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) != 0) wait_size(1);
      else wait_size(0);
      for (int i = 0; i < N; i++) begin
        t_e[i]    = ($urandom_range(0, 3) != 0);
        t_vppn[i] = pool[$urandom_range(0, 3)];
        t_ps[i]   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
        t_asid[i] = 10'($urandom_range(0, 3));
        t_g[i]    = 1'($urandom_range(0, 1));
      end
      issue(5'($urandom_range(0, 7)), 10'($urandom_range(0, 3)),
            {pool[$urandom_range(0, 3)], 13'($urandom_range(0, 8191))});
    end
    wait_size(0);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
